spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Shares one SPI master controller among NREQ requesters using round-robin arbitration.
- Runs one transaction (write, or read of one byte) per grant: latches the request, releases the controller from reset, holds its command inputs stable, waits for done, routes the result back to the winning requester and parks the controller in reset again.
- A watchdog aborts transactions whose slave never completes.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 1024, maximum cycles in RUN before abort (>=64)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester request valid; held until accepted
- req_wr  in  NREQ  1=write, 0=read
- req_addr  in  8*NREQ  register address; slice i belongs to requester i
- req_wdata  in  8*NREQ  write data; slice i belongs to requester i
- req_ready  out  NREQ  accept strobe (combinational, one-hot)
- rsp_valid  out  NREQ  one-cycle response strobe for requester i
- rsp_rdata  out  8  read data, shared bus, qualified by rsp_valid
- rsp_error  out  1  controller error or timeout
- rsp_timeout  out  1  transaction aborted by watchdog
- ctrl_rst  out  1  reset to the controller, active-high
- ctrl_wr  out  1  controller wr input
- ctrl_addr  out  8  controller addr input
- ctrl_wdata  out  8  controller data_in input
- ctrl_done  in  1  controller done (one-cycle pulse)
- ctrl_error  in  1  controller error, valid with ctrl_done
- ctrl_rdata  in  8  controller data_out, valid with ctrl_done
- busy  out  1  high in RUN and RESP
- grant_id  out  3  index of the current or last granted requester

Behaviour:
Reset values:
- ctrl_rst=1.
- ctrl_wr, ctrl_addr, ctrl_wdata = 0.
- rsp_* = 0; busy = 0; grant_id = 0.
- Round-robin pointer = NREQ-1, so requester 0 has first priority.
- Watchdog counter = 0; state = IDLE.

States: IDLE -> RUN -> RESP -> IDLE.

IDLE:
- ctrl_rst=1.
- Winner = first i with req_valid[i]=1, searching from pointer+1 upward with wrap modulo NREQ.
- req_ready[winner]=1 in the same cycle (combinational from req_valid and state). All other req_ready bits are 0. req_ready is 0 in every state other than IDLE.
- On the handshake, register the winner's wr/addr/wdata into ctrl_wr/ctrl_addr/ctrl_wdata, set grant_id=winner and pointer=winner, clear the watchdog, and go to RUN.

RUN:
- ctrl_rst=0 (registered, so first low in the cycle after the handshake).
- ctrl_* are held constant for the entire RUN state. Requester inputs are ignored.
- Watchdog increments each cycle.
- ctrl_done=1: capture ctrl_rdata, ctrl_error; set ctrl_rst=1 on the next edge; go to RESP.
- Otherwise, watchdog == TIMEOUT_CYCLES-1: set rdata=0, error=1, timeout=1; ctrl_rst=1 next edge; go to RESP.
- ctrl_done and watchdog expiry in the same cycle: done wins, and timeout is not flagged.

RESP (exactly one cycle):
- rsp_valid[grant_id]=1 with rsp_rdata/rsp_error/rsp_timeout. These outputs are registered and return to 0 the following cycle.
- rsp_rdata equals ctrl_rdata for reads; it is don't-care for writes but driven with the captured value.
- Go to IDLE. The earliest next grant is in the cycle after RESP.

Further rules:
- ctrl_rst is high in IDLE and RESP. This guarantees the controller cannot auto-start a second transaction.
- ctrl_done observed outside RUN is ignored.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NREQ-1,0.
- Reset mid-RUN: abort immediately. All outputs take their reset values, no rsp_valid is issued, and the pointer returns to NREQ-1.
- Watchdog width is clog2(TIMEOUT_CYCLES+1). The counter saturates rather than wraps.

Test Plan:
- Single write: req_valid[1]=1, wr=1, addr=0x05, wdata=0xA5 -> req_ready[1] in the same cycle; ctrl_addr=0x05 and ctrl_wdata=0xA5 stable while ctrl_rst=0; model pulses ctrl_done -> rsp_valid[1] one cycle, rsp_error=0; ctrl_rst=1 the cycle after done.
- Read: req 2, wr=0, addr=0x10; model returns ctrl_rdata=0x3C with done -> rsp_valid[2], rsp_rdata=0x3C.
- Contention: req 0, 2, 3 valid simultaneously from reset -> grant order 0, 2, 3; with all four continuously valid -> 0, 1, 2, 3, 0.
- Controller error: addr=0x40 write, model returns done with ctrl_error=1 -> rsp_error=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYCLES=64, model never pulses done -> after 64 RUN cycles rsp_valid with rsp_error=1, rsp_timeout=1, rsp_rdata=0, ctrl_rst=1; done arriving on the expiry cycle -> normal response.
- Reset during RUN (cycle 10 of a read) -> ctrl_rst=1 and busy=0 next cycle, no rsp_valid; the next request from requester 0 is granted first.

Source files
------------

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that lends one SPI master controller to NREQ requesters,
// one transaction per grant, with a watchdog that aborts hung transactions.
module spi_txn_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic              ctrl_rst,
    output logic              ctrl_wr,
    output logic [7:0]        ctrl_addr,
    output logic [7:0]        ctrl_wdata,
    input  logic              ctrl_done,
    input  logic              ctrl_error,
    input  logic [7:0]        ctrl_rdata,
    output logic              busy,
    output logic [2:0]        grant_id
);

    localparam int PW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic            found;
    logic [WDW-1:0]  wd;
    logic            sel_wr;
    logic [7:0]      sel_addr;
    logic [7:0]      sel_wdata;

    function automatic logic [WDW-1:0] wd_sat_inc(input logic [WDW-1:0] v);
        return (v == {WDW{1'b1}}) ? v : v + WDW'(1);
    endfunction

    // Search starts just after the last winner, so the last winner has lowest priority.
    always_comb begin : pick
        logic [PW-1:0] cand;
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = 8'h00;
        sel_wdata = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[8*i +: 8];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= PW'(NREQ - 1);
            grant_id    <= 3'd0;
            wd          <= '0;
            busy        <= 1'b0;
            ctrl_rst    <= 1'b1;
            ctrl_wr     <= 1'b0;
            ctrl_addr   <= 8'h00;
            ctrl_wdata  <= 8'h00;
            rsp_valid   <= '0;
            rsp_rdata   <= 8'h00;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        ctrl_wr    <= sel_wr;
                        ctrl_addr  <= sel_addr;
                        ctrl_wdata <= sel_wdata;
                        grant_id   <= 3'(win);
                        ptr        <= win;
                        wd         <= '0;
                        busy       <= 1'b1;
                        ctrl_rst   <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Done has priority over an expiry landing on the same cycle.
                    if (ctrl_done) begin
                        rsp_valid      <= '0;
                        rsp_valid[ptr] <= 1'b1;
                        rsp_rdata      <= ctrl_rdata;
                        rsp_error      <= ctrl_error;
                        rsp_timeout    <= 1'b0;
                        ctrl_rst       <= 1'b1;
                        state          <= RESP;
                    end else if (wd == WDW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid      <= '0;
                        rsp_valid[ptr] <= 1'b1;
                        rsp_rdata      <= 8'h00;
                        rsp_error      <= 1'b1;
                        rsp_timeout    <= 1'b1;
                        ctrl_rst       <= 1'b1;
                        state          <= RESP;
                    end else begin
                        wd <= wd_sat_inc(wd);
                    end
                end
                RESP: begin
                    rsp_valid   <= '0;
                    rsp_rdata   <= 8'h00;
                    rsp_error   <= 1'b0;
                    rsp_timeout <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: directed scenarios plus random traffic, checked
// against a transaction-timeline model of arbitration and response timing.
module tb_spi_txn_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid, req_wr, req_ready, rsp_valid;
    logic [8*N-1:0]   req_addr, req_wdata;
    logic [7:0]       rsp_rdata, ctrl_addr, ctrl_wdata, ctrl_rdata;
    logic             rsp_error, rsp_timeout, ctrl_rst, ctrl_wr;
    logic             ctrl_done, ctrl_error, busy;
    logic [2:0]       grant_id;

    spi_txn_arbiter #(.NREQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .ctrl_rst(ctrl_rst), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_done(ctrl_done), .ctrl_error(ctrl_error), .ctrl_rdata(ctrl_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // pending requests held by each requester
    bit       p_valid [N];
    bit       p_wr    [N];
    logic [7:0] p_addr  [N];
    logic [7:0] p_wdata [N];

    // model: round-robin pointer, last grant, and the active transaction timeline
    int m_ptr = N - 1;
    int m_gid = 0;
    bit t_active = 0;
    int t_start, t_len, t_lat, t_req;
    bit t_done, t_wr, t_err;
    logic [7:0] t_addr, t_wdata, t_rdata;

    int f_lat = -1, f_err = -1, f_rdata = -1;
    bit rnd = 0, refill = 0;
    int glog[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at window %0d: got=%0h expected=%0h", tag, n, got, exp);
        end
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (p_valid[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pick_lat();
        int r = $urandom_range(0, 9);
        if (r == 0) return TO;
        if (r == 1) return TO + 6;
        return $urandom_range(1, 20);
    endfunction

    task automatic set_req(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d);
        p_valid[i] = 1'b1; p_wr[i] = wr; p_addr[i] = a; p_wdata[i] = d;
    endtask

    task automatic window(input bit rst_now);
        bit in_run, in_resp, idle;
        int w;
        logic [N-1:0] exp_ready;
        if (t_active && n > t_start + t_len) t_active = 0;
        in_run  = t_active && n >= t_start && n < t_start + t_len;
        in_resp = t_active && n == t_start + t_len;
        idle    = !t_active;

        chk("ctrl_rst", ctrl_rst, !in_run);
        chk("busy", busy, in_run || in_resp);
        chk("rsp_valid", rsp_valid, in_resp ? (1 << t_req) : 0);
        chk("grant_id", grant_id, m_gid);
        if (in_run) begin
            chk("ctrl_wr", ctrl_wr, t_wr);
            chk("ctrl_addr", ctrl_addr, t_addr);
            chk("ctrl_wdata", ctrl_wdata, t_wdata);
        end
        if (in_resp) begin
            chk("rsp_rdata", rsp_rdata, t_done ? t_rdata : 8'h00);
            chk("rsp_error", rsp_error, t_done ? t_err : 1'b1);
            chk("rsp_timeout", rsp_timeout, !t_done);
        end else begin
            chk("rsp_quiet", {rsp_rdata, rsp_error, rsp_timeout}, 0);
        end

        // controller model; stray done pulses outside RUN must be ignored
        ctrl_done  = 1'b0;
        ctrl_error = 1'($urandom);
        ctrl_rdata = 8'($urandom);
        if (!rst_now) begin
            if (in_run && (n - t_start + 1) == t_lat) begin
                ctrl_done = 1'b1; ctrl_error = t_err; ctrl_rdata = t_rdata;
            end else if (!in_run && $urandom_range(0, 7) == 0) begin
                ctrl_done = 1'b1;
            end
        end

        for (int i = 0; i < N; i++) begin
            if ((refill || (rnd && $urandom_range(0, 3) == 0)) && !p_valid[i])
                set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
            req_valid[i] = p_valid[i];
            req_wr[i]    = p_valid[i] ? p_wr[i] : 1'($urandom);
            req_addr[8*i +: 8]  = p_valid[i] ? p_addr[i]  : 8'($urandom);
            req_wdata[8*i +: 8] = p_valid[i] ? p_wdata[i] : 8'($urandom);
        end
        reset = rst_now;
        #1;

        w = -1;
        for (int k = 1; k <= N; k++)
            if (w < 0 && p_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        exp_ready = (idle && w >= 0) ? N'(1 << w) : '0;
        if (!rst_now) begin
            chk("req_ready", req_ready, exp_ready);
            for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
            if (idle && w >= 0) begin
                p_valid[w] = 1'b0;
                t_active = 1; t_start = n + 1; t_req = w;
                t_wr = p_wr[w]; t_addr = p_addr[w]; t_wdata = p_wdata[w];
                t_lat  = (f_lat >= 0) ? f_lat : pick_lat();
                t_done = (t_lat <= TO);
                t_len  = t_done ? t_lat : TO;
                t_err  = (f_err >= 0) ? f_err[0] : 1'($urandom);
                t_rdata = (f_rdata >= 0) ? 8'(f_rdata) : 8'($urandom);
                m_ptr = w; m_gid = w;
            end
        end else begin
            t_active = 0; m_ptr = N - 1; m_gid = 0;
        end
        @(posedge clk); #1; n++;
    endtask

    task automatic drain(input int max);
        int c = 0;
        while ((t_active || any_pending() || refill) && c < max) begin
            window(1'b0); c++;
        end
        chk("drain_within_bound", c < max, 1'b1);
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        chk({tag, "_count"}, glog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < glog.size(); i++)
            chk(tag, glog[i], exp[i]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit reached at window %0d", n);
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        ctrl_done = 1'b0; ctrl_error = 1'b0; ctrl_rdata = 8'h00;
        for (int i = 0; i < N; i++) begin p_valid[i] = 0; p_wr[i] = 0; p_addr[i] = 0; p_wdata[i] = 0; end
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;

        chk("rst_ctrl_rst", ctrl_rst, 1'b1);
        chk("rst_ctrl_cmd", {ctrl_wr, ctrl_addr, ctrl_wdata}, 0);
        chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_timeout}, 0);
        chk("rst_busy_gid", {busy, grant_id}, 0);
        chk("rst_ready", req_ready, 0);

        // single write
        f_lat = 5; f_err = 0;
        set_req(1, 1'b1, 8'h05, 8'hA5);
        glog.delete(); drain(200); check_log("write_grant", '{1});

        // read returning 0x3C
        f_lat = 7; f_rdata = 8'h3C;
        set_req(2, 1'b0, 8'h10, 8'h00);
        glog.delete(); drain(200); check_log("read_grant", '{2});
        f_rdata = -1;

        // contention straight out of reset
        window(1'b1);
        f_lat = 3;
        set_req(0, 1'b1, 8'h01, 8'h11); set_req(2, 1'b0, 8'h02, 8'h22); set_req(3, 1'b1, 8'h03, 8'h33);
        glog.delete(); drain(300); check_log("contention", '{0, 2, 3});

        // all four continuously valid
        refill = 1; glog.delete();
        for (int c = 0; c < 300 && glog.size() < 5; c++) window(1'b0);
        refill = 0;
        begin
            int first5[$];
            for (int i = 0; i < 5 && i < glog.size(); i++) first5.push_back(glog[i]);
            glog = first5;
        end
        check_log("fairness", '{0, 1, 2, 3, 0});
        drain(500);

        // controller error
        f_lat = 4; f_err = 1;
        set_req(1, 1'b1, 8'h40, 8'h5A);
        drain(200);

        // watchdog expiry, then done on the expiry cycle
        f_err = 0; f_lat = 1000;
        set_req(3, 1'b0, 8'h20, 8'h00);
        drain(300);
        f_lat = TO; f_rdata = 8'h77;
        set_req(0, 1'b0, 8'h21, 8'h00);
        drain(300);
        f_rdata = -1;

        // reset during RUN cycle 10 of a read
        f_lat = 1000;
        set_req(2, 1'b0, 8'h30, 8'h00);
        for (int c = 0; c < 100 && !(t_active && n == t_start + 9); c++) window(1'b0);
        chk("reached_run_cycle10", t_active && n == t_start + 9, 1'b1);
        window(1'b1);
        f_lat = 2;
        set_req(1, 1'b1, 8'h31, 8'h01); set_req(0, 1'b1, 8'h32, 8'h02);
        glog.delete(); drain(200); check_log("after_reset", '{0, 1});

        // random traffic with occasional resets
        f_lat = -1; f_err = -1; f_rdata = -1; rnd = 1;
        for (int c = 0; c < 3000; c++) window($urandom_range(0, 499) == 0);
        rnd = 0;
        drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
